// File: rtl/mem_read_hls_deadlock_controller_pkg.sv
// Shared types and default widths for the mem_read deadlock supervisor.
// Imported by the interface, the encoder and the top.
package mem_read_deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WATCH     = 2'd1,
    CONFIRMED = 2'd2,
    REPORTED  = 2'd3
  } dl_state_t;

  localparam int NUM_MON_D  = 4;
  localparam int THRESH_W_D = 16;
  localparam int IDX_W_D    =
    (NUM_MON_D > 1) ? $clog2(NUM_MON_D) : 1;
  localparam int DL_CNT_W   = 8;

endpackage

// File: rtl/mem_read_hls_deadlock_controller_if.sv
// Deadlock report channel: valid/ready plus payload.
// The controller drives it through the master modport.
interface mem_read_hls_deadlock_controller_if
  import mem_read_deadlock_pkg::*;
#(
  parameter int NUM_MON = NUM_MON_D,
  parameter int IDX_W   = IDX_W_D
);

  logic               rpt_valid;
  logic               rpt_ready;
  logic [NUM_MON-1:0] rpt_mask;
  logic [IDX_W-1:0]   rpt_first_idx;

  modport master (
    output rpt_valid,
    output rpt_mask,
    output rpt_first_idx,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid,
    input  rpt_mask,
    input  rpt_first_idx,
    output rpt_ready
  );

endinterface

// File: rtl/mem_read_hls_deadlock_controller_prio_enc.sv
// Lowest-set-bit encoder; returns 0 for an all-zero vector.
// Used to name the first blocked monitor of an episode.
module mem_read_deadlock_prio_enc
  import mem_read_deadlock_pkg::*;
#(
  parameter int NUM_MON = NUM_MON_D,
  parameter int IDX_W   = IDX_W_D
) (
  input  logic [NUM_MON-1:0] vec,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    idx = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/mem_read_hls_deadlock_controller.sv
// Qualifies monitor blocks, confirms persistent blocking and
// holds a sticky deadlock report until cleared.
module mem_read_hls_deadlock_controller
  import mem_read_deadlock_pkg::*;
#(
  parameter int NUM_MON  = NUM_MON_D,
  parameter int THRESH_W = THRESH_W_D,
  parameter int IDX_W    = IDX_W_D
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic [THRESH_W-1:0] threshold,
  input  logic [NUM_MON-1:0]  mon_block,
  input  logic [NUM_MON-1:0]  inst_idle,
  mem_read_hls_deadlock_controller_if.master rpt,
  output logic                deadlock,
  output logic [DL_CNT_W-1:0] deadlock_cnt
);

  dl_state_t state, state_n;

  logic [THRESH_W-1:0] cnt, cnt_n;
  logic [THRESH_W-1:0] thr_q, thr_n;
  logic [NUM_MON-1:0]  mask_q, mask_n;
  logic [IDX_W-1:0]    idx_q, idx_n;
  logic                valid_q, valid_n;
  logic                dl_q, dl_n;
  logic [DL_CNT_W-1:0] dcnt, dcnt_n;

  logic [NUM_MON-1:0]  eff;
  logic                any_blk;
  logic [IDX_W-1:0]    low_idx;
  logic [THRESH_W-1:0] thr_in;

  assign eff     = mon_block & ~inst_idle;
  assign any_blk = |eff;
  // a zero threshold still needs one extra blocked sample
  assign thr_in  = (threshold == '0) ?
                   THRESH_W'(1) : threshold;

  mem_read_deadlock_prio_enc #(
    .NUM_MON (NUM_MON),
    .IDX_W   (IDX_W)
  ) u_enc (
    .vec (eff),
    .idx (low_idx)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    thr_n   = thr_q;
    mask_n  = mask_q;
    idx_n   = idx_q;
    valid_n = valid_q;
    dl_n    = dl_q;
    dcnt_n  = dcnt;
    if (clear) begin
      state_n = IDLE;
      cnt_n   = '0;
      mask_n  = '0;
      idx_n   = '0;
      valid_n = 1'b0;
      dl_n    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && any_blk) begin
            state_n = WATCH;
            cnt_n   = THRESH_W'(1);
            thr_n   = thr_in;
            mask_n  = eff;
            idx_n   = low_idx;
          end
        end
        WATCH: begin
          if (!enable || !any_blk) begin
            state_n = IDLE;
            cnt_n   = '0;
            mask_n  = '0;
            idx_n   = '0;
          end else if (cnt == thr_q) begin
            state_n = CONFIRMED;
            valid_n = 1'b1;
            dl_n    = 1'b1;
            if (dcnt != '1) dcnt_n = dcnt + 1'b1;
          end else begin
            cnt_n  = cnt + 1'b1;
            mask_n = mask_q | eff;
          end
        end
        CONFIRMED: begin
          if (rpt.rpt_ready) begin
            state_n = REPORTED;
            valid_n = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      thr_q   <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      dl_q    <= 1'b0;
      dcnt    <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      thr_q   <= thr_n;
      mask_q  <= mask_n;
      idx_q   <= idx_n;
      valid_q <= valid_n;
      dl_q    <= dl_n;
      dcnt    <= dcnt_n;
    end
  end

  assign rpt.rpt_valid     = valid_q;
  assign rpt.rpt_mask      = mask_q;
  assign rpt.rpt_first_idx = idx_q;
  assign deadlock          = dl_q;
  assign deadlock_cnt      = dcnt;

endmodule

// File: tb/tb_mem_read_hls_deadlock_controller.sv
// Self-checking bench: vector table, corner sequences and
// randomized traffic against an episode-level reference model.
module tb_mem_read_hls_deadlock_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        clear;
  logic [15:0] threshold;
  logic [3:0]  mon_block;
  logic [3:0]  inst_idle;
  logic        deadlock;
  logic [7:0]  deadlock_cnt;

  int ntests = 0;
  int nfail  = 0;

  mem_read_hls_deadlock_controller_if #(
    .NUM_MON (4),
    .IDX_W   (2)
  ) rif ();

  mem_read_hls_deadlock_controller #(
    .NUM_MON  (4),
    .THRESH_W (16),
    .IDX_W    (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .clear        (clear),
    .threshold    (threshold),
    .mon_block    (mon_block),
    .inst_idle    (inst_idle),
    .rpt          (rif),
    .deadlock     (deadlock),
    .deadlock_cnt (deadlock_cnt)
  );

  always #5 clock = ~clock;

  // reference model: phase 0 idle, 1 watching, 2 reported-pending,
  // 3 delivered; run = consecutive qualified-blocked samples
  int m_phase, m_run, m_need, m_mask, m_first, m_cnt;

  task automatic chk(input string nm, input int act,
                     input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_run = 0; m_need = 0;
    m_mask = 0; m_first = 0; m_cnt = 0;
  endtask

  function automatic int lowest(input int v);
    for (int i = 0; i < 4; i++)
      if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_edge(input bit en, input bit clr,
                            input int th, input int mb,
                            input int ii, input bit rdy);
    int e;
    e = mb & ~ii & 15;
    if (clr) begin
      m_phase = 0; m_run = 0; m_mask = 0; m_first = 0;
    end else if (m_phase == 0) begin
      if (en && e != 0) begin
        m_phase = 1; m_run = 1;
        m_need  = (th == 0) ? 2 : th + 1;
        m_mask  = e; m_first = lowest(e);
      end
    end else if (m_phase == 1) begin
      if (!en || e == 0) begin
        m_phase = 0; m_run = 0; m_mask = 0; m_first = 0;
      end else if (m_run + 1 >= m_need) begin
        m_phase = 2;
        if (m_cnt < 255) m_cnt++;
      end else begin
        m_run++;
        m_mask |= e;
      end
    end else if (m_phase == 2) begin
      if (rdy) m_phase = 3;
    end
  endtask

  task automatic check_model();
    chk("valid", int'(rif.rpt_valid), int'(m_phase == 2));
    chk("deadlock", int'(deadlock), int'(m_phase >= 2));
    chk("dl_cnt", int'(deadlock_cnt), m_cnt);
    chk("mask", int'(rif.rpt_mask), m_mask);
    chk("first_idx", int'(rif.rpt_first_idx), m_first);
  endtask

  task automatic step(input bit en, input bit clr,
                      input int th, input int mb,
                      input int ii, input bit rdy);
    enable = en; clear = clr; threshold = 16'(th);
    mon_block = 4'(mb); inst_idle = 4'(ii);
    rif.rpt_ready = rdy;
    @(posedge clock);
    model_edge(en, clr, th, mb, ii, rdy);
    #1;
    check_model();
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_valid", int'(rif.rpt_valid), 0);
    chk("rst_dl", int'(deadlock), 0);
    chk("rst_cnt", int'(deadlock_cnt), 0);
    chk("rst_mask", int'(rif.rpt_mask), 0);
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  typedef struct {
    bit en; bit clr; int th; int mb; int ii; bit rdy;
    int e_valid; int e_dl; int e_mask; int e_idx;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int saved;
    tbl[0]  = '{1, 0, 4, 4, 0, 0, 0, 0, 4, 2};
    tbl[1]  = '{1, 0, 4, 4, 0, 0, 0, 0, 4, 2};
    tbl[2]  = '{1, 0, 9, 4, 0, 0, 0, 0, 4, 2};
    tbl[3]  = '{1, 0, 9, 4, 0, 0, 0, 0, 4, 2};
    tbl[4]  = '{1, 0, 9, 4, 0, 0, 1, 1, 4, 2};
    tbl[5]  = '{0, 0, 4, 0, 0, 1, 0, 1, 4, 2};
    tbl[6]  = '{0, 0, 4, 15, 0, 0, 0, 1, 4, 2};
    tbl[7]  = '{1, 1, 4, 15, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{1, 0, 4, 15, 15, 0, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 4, 1, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{1, 0, 4, 10, 2, 0, 0, 0, 8, 3};
    tbl[11] = '{1, 0, 4, 0, 0, 0, 0, 0, 0, 0};

    reset = 1'b1; enable = 0; clear = 0; threshold = 0;
    mon_block = 0; inst_idle = 0; rif.rpt_ready = 0;
    model_reset();
    #12;
    chk("reset_valid", int'(rif.rpt_valid), 0);
    chk("reset_dl", int'(deadlock), 0);
    chk("reset_cnt", int'(deadlock_cnt), 0);
    chk("reset_mask", int'(rif.rpt_mask), 0);
    chk("reset_idx", int'(rif.rpt_first_idx), 0);
    @(posedge clock);
    #1 reset = 1'b0;

    // vectors: basic confirm at edge 4, deliver, clear, idle masking
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].en, tbl[i].clr, tbl[i].th, tbl[i].mb,
           tbl[i].ii, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i),
          int'(rif.rpt_valid), tbl[i].e_valid);
      chk($sformatf("tbl%0d_dl", i),
          int'(deadlock), tbl[i].e_dl);
      chk($sformatf("tbl%0d_mask", i),
          int'(rif.rpt_mask), tbl[i].e_mask);
      chk($sformatf("tbl%0d_idx", i),
          int'(rif.rpt_first_idx), tbl[i].e_idx);
    end
    chk("tbl_cnt", int'(deadlock_cnt), 1);

    // all blocked but all idle: never leaves idle
    for (int i = 0; i < 100; i++) step(1, 0, 1, 15, 15, 1);
    chk("idle_all_dl", int'(deadlock), 0);

    // interrupted run restarts the episode
    for (int i = 0; i < 3; i++) step(1, 0, 4, 1, 0, 0);
    step(1, 0, 4, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 4, 1, 0, 0);
    chk("restart_not_yet", int'(rif.rpt_valid), 0);
    step(1, 0, 4, 1, 0, 0);
    chk("restart_conf", int'(rif.rpt_valid), 1);
    chk("restart_cnt", int'(deadlock_cnt), 2);
    step(1, 1, 4, 1, 0, 0);

    // threshold 0, payload stable under back-pressure
    step(1, 0, 0, 2, 0, 0);
    step(1, 0, 0, 10, 0, 0);
    chk("thr0_valid", int'(rif.rpt_valid), 1);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 7, i, 0, 0);
      chk("bp_mask", int'(rif.rpt_mask), 2);
      chk("bp_idx", int'(rif.rpt_first_idx), 1);
      chk("bp_valid", int'(rif.rpt_valid), 1);
    end
    step(1, 0, 0, 15, 0, 1);
    chk("hs_valid", int'(rif.rpt_valid), 0);
    chk("hs_dl", int'(deadlock), 1);
    step(1, 1, 0, 0, 0, 0);

    // clear wins over a same-cycle handshake
    step(1, 0, 0, 8, 0, 0);
    step(1, 0, 0, 8, 0, 0);
    saved = int'(deadlock_cnt);
    step(1, 1, 0, 8, 0, 1);
    chk("clr_rdy_valid", int'(rif.rpt_valid), 0);
    chk("clr_rdy_dl", int'(deadlock), 0);
    chk("clr_rdy_cnt", int'(deadlock_cnt), saved);
    chk("clr_rdy_cnt4", saved, 4);

    // async reset mid-watch and while reported
    step(1, 0, 4, 4, 0, 0);
    step(1, 0, 4, 4, 0, 0);
    async_reset();
    step(1, 0, 0, 4, 0, 0);
    step(1, 0, 0, 4, 0, 1);
    step(1, 0, 0, 4, 0, 1);
    chk("pre_rst_dl", int'(deadlock), 1);
    async_reset();

    // saturation of the confirmed-deadlock counter
    for (int i = 0; i < 256; i++) begin
      step(1, 0, 0, 1, 0, 0);
      step(1, 0, 0, 1, 0, 0);
      step(1, 1, 0, 0, 0, 0);
    end
    chk("sat_cnt", int'(deadlock_cnt), 255);

    async_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 15) != 0,
           $urandom_range(0, 40) == 0,
           $urandom_range(0, 5),
           $urandom_range(0, 15),
           ($urandom_range(0, 3) == 0) ?
             $urandom_range(0, 15) : 0,
           $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
